// File: rtl/ltc2387_decimator_if.sv
// Result handshake between the LTC2387 decimator and the downstream fabric
// consumer, such as a FIFO or DMA. The decimator drives the master modport.
interface ltc2387_decimator_if #(
    parameter int ADC_WIDTH = 18
);
    logic [ADC_WIDTH-1:0] avg_data;
    logic                 avg_valid;
    logic                 avg_ready;

    modport master (output avg_data, output avg_valid, input avg_ready);
    modport slave  (input avg_data, input avg_valid, output avg_ready);
endinterface

// File: rtl/ltc2387_decimator.sv
// Boxcar decimator for reconstructed LTC2387 samples. It averages 2^k
// consecutive accepted samples and presents each result on a valid/ready
// handshake. Results that complete while an earlier result is still unaccepted
// are dropped, and the overrun counter records each drop.
// Build option: LTC2387_DEC_ROUND_EN adds round-half-up before the shift.
// When it is not defined, the shift truncates toward -inf.
module ltc2387_decimator #(
    parameter int ADC_WIDTH     = 18,
    parameter int MAX_LOG2_DEC  = 8,
    parameter int OVR_CNT_WIDTH = 16
) (
    input  logic                     sys_clk_int,
    input  logic                     reset_int,
    input  logic                     enable,
    input  logic [3:0]               dec_log2,
    input  logic [ADC_WIDTH-1:0]     adc_data_in,
    input  logic                     adc_valid_in,
    ltc2387_decimator_if.master      avg_if,
    output logic                     busy,
    output logic [OVR_CNT_WIDTH-1:0] overrun_cnt
);
    localparam int ACC_W = ADC_WIDTH + MAX_LOG2_DEC;
    localparam int CNT_W = MAX_LOG2_DEC + 1;

    logic                    valid_d;
    logic [3:0]              k_lat;
    logic [CNT_W-1:0]        count;
    logic signed [ACC_W-1:0] acc;
    logic [ADC_WIDTH-1:0]    avg_data_q;
    logic                    avg_valid_q;

    logic                    accept;
    logic [3:0]              k_clamp;
    logic [3:0]              k_eff;
    logic [CNT_W-1:0]        count_next;
    logic [CNT_W-1:0]        block_len;
    logic                    block_done;
    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] sum_rnd;
    logic signed [ACC_W-1:0] shifted;
    logic [ADC_WIDTH-1:0]    avg_next;

    // Detect sample edges, choose k for this block, and build the next average.
    // While count is zero, the incoming sample starts a new block. That sample
    // uses the freshly clamped k, not the stale k_lat.
    always_comb begin
        accept     = adc_valid_in && !valid_d && enable;
        k_clamp    = (dec_log2 > 4'(MAX_LOG2_DEC)) ? 4'(MAX_LOG2_DEC) : dec_log2;
        k_eff      = (count == '0) ? k_clamp : k_lat;
        count_next = count + CNT_W'(1);
        block_len  = CNT_W'(1) << k_eff;
        block_done = accept && (count_next == block_len);
        sample_ext = {{MAX_LOG2_DEC{adc_data_in[ADC_WIDTH-1]}}, adc_data_in};
        sum        = acc + sample_ext;
`ifdef LTC2387_DEC_ROUND_EN
        sum_rnd    = (k_eff != 4'd0) ? sum + (ACC_W'(1) << (k_eff - 4'd1)) : sum;
`else
        sum_rnd    = sum;
`endif
        shifted    = sum_rnd >>> k_eff;
        avg_next   = ADC_WIDTH'(shifted);
    end

    // Accumulate samples, then publish results or count overruns.
    always_ff @(posedge sys_clk_int) begin
        if (reset_int) begin
            valid_d     <= 1'b0;
            k_lat       <= 4'd0;
            count       <= '0;
            acc         <= '0;
            avg_data_q  <= '0;
            avg_valid_q <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            valid_d <= adc_valid_in;

            if (!enable) begin
                acc   <= '0;
                count <= '0;
            end else if (accept) begin
                if (count == '0) begin
                    k_lat <= k_clamp;
                end
                if (block_done) begin
                    acc   <= '0;
                    count <= '0;
                end else begin
                    acc   <= sum;
                    count <= count_next;
                end
            end

            if (block_done) begin
                if (!avg_valid_q || avg_if.avg_ready) begin
                    avg_data_q  <= avg_next;
                    avg_valid_q <= 1'b1;
                end else if (overrun_cnt != '1) begin
                    overrun_cnt <= overrun_cnt + OVR_CNT_WIDTH'(1);
                end
            end else if (avg_if.avg_ready) begin
                avg_valid_q <= 1'b0;
            end
        end
    end

    assign avg_if.avg_data  = avg_data_q;
    assign avg_if.avg_valid = avg_valid_q;
    assign busy             = (count != '0);
endmodule

// File: tb/tb_ltc2387_decimator.sv
// Self-checking bench for ltc2387_decimator.
// Directed cases pin known values. A random phase is then checked on every
// cycle against a block-level reference model.
module tb_ltc2387_decimator;
    localparam int ADC_WIDTH = 18;
    localparam int MAX_K     = 8;
    localparam int OVR_MAX   = 65535;
`ifdef LTC2387_DEC_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic                 sys_clk_int = 1'b0;
    logic                 reset_int   = 1'b1;
    logic                 enable      = 1'b1;
    logic [3:0]           dec_log2    = 4'd0;
    logic [17:0]          adc_data_in = '0;
    logic                 adc_valid_in = 1'b0;
    logic                 busy;
    logic [15:0]          overrun_cnt;

    ltc2387_decimator_if #(.ADC_WIDTH(ADC_WIDTH)) avg_bus ();

    ltc2387_decimator #(
        .ADC_WIDTH(ADC_WIDTH), .MAX_LOG2_DEC(MAX_K), .OVR_CNT_WIDTH(16)
    ) dut (
        .sys_clk_int (sys_clk_int),
        .reset_int   (reset_int),
        .enable      (enable),
        .dec_log2    (dec_log2),
        .adc_data_in (adc_data_in),
        .adc_valid_in(adc_valid_in),
        .avg_if      (avg_bus),
        .busy        (busy),
        .overrun_cnt (overrun_cnt)
    );

    always #5 sys_clk_int = ~sys_clk_int;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sx(input logic [17:0] v);
        return int'($signed(v));
    endfunction

    // Reference: a block average is floor((sum [+ n/2]) / n).
    function automatic longint floor_div(input longint s, input longint n);
        if (s >= 0) return s / n;
        return -((-s + n - 1) / n);
    endfunction

    int     q[$];
    bit     m_vd;
    int     m_k;
    bit     m_av;
    int     m_avg;
    int     m_ovr;

    function automatic int block_avg();
        longint s = 0;
        longint n = longint'(1) << m_k;
        foreach (q[i]) s += q[i];
        if (ROUND && m_k > 0) s += n / 2;
        return int'(floor_div(s, n));
    endfunction

    // Model step on each posedge, then compare #1 later.
    initial begin
        bit r, en, v, rd, acc_ok, cmpl;
        int d, dl, res;
        forever begin
            @(posedge sys_clk_int);
            r = reset_int; en = enable; v = adc_valid_in; rd = avg_bus.avg_ready;
            d = sx(adc_data_in); dl = int'(dec_log2);
            res = 0;
            cmpl = 1'b0;
            if (r) begin
                q.delete(); m_vd = 0; m_k = 0; m_av = 0; m_avg = 0; m_ovr = 0;
            end else begin
                acc_ok = v && !m_vd && en;
                if (!en) q.delete();
                else if (acc_ok) begin
                    if (q.size() == 0) m_k = (dl > MAX_K) ? MAX_K : dl;
                    q.push_back(d);
                    if (q.size() == (1 << m_k)) begin
                        res = block_avg();
                        cmpl = 1'b1;
                        q.delete();
                    end
                end
                if (cmpl) begin
                    if (!m_av || rd) begin m_avg = res; m_av = 1; end
                    else if (m_ovr < OVR_MAX) m_ovr++;
                end else if (rd) m_av = 0;
                m_vd = v;
            end
            #1;
            if (chk_en) begin
                check("avg_valid", int'(avg_bus.avg_valid), int'(m_av));
                check("avg_data", sx(avg_bus.avg_data), m_avg);
                check("busy", int'(busy), int'(q.size() != 0));
                check("overrun_cnt", int'(overrun_cnt), m_ovr);
            end
        end
    end

    task automatic tick();
        @(negedge sys_clk_int);
    endtask

    // One sample pulse. On return, the accept edge has just passed.
    task automatic send(input int v);
        adc_valid_in = 1'b0;
        tick();
        adc_data_in  = 18'(v);
        adc_valid_in = 1'b1;
        tick();
        adc_valid_in = 1'b0;
    endtask

    initial begin
        int vcount;
        avg_bus.avg_ready = 1'b1;
        tick(); tick();
        reset_int = 1'b0;
        chk_en = 1'b1;
        tick();
        check("reset avg_data", sx(avg_bus.avg_data), 0);
        check("reset avg_valid", int'(avg_bus.avg_valid), 0);
        check("reset busy", int'(busy), 0);
        check("reset overrun", int'(overrun_cnt), 0);

        // k=0 pass-through
        dec_log2 = 4'd0;
        send(5);
        check("k0 first", sx(avg_bus.avg_data), 5);
        check("k0 first valid", int'(avg_bus.avg_valid), 1);
        send(-3);
        check("k0 second", sx(avg_bus.avg_data), -3);

        // k=2 on samples 1..4
        dec_log2 = 4'd2;
        send(1); send(2); send(3);
        check("k2 busy mid", int'(busy), 1);
        send(4);
        check("k2 avg", sx(avg_bus.avg_data), ROUND ? 3 : 2);

        // k=1 sign and range extremes
        dec_log2 = 4'd1;
        send(-1); send(-2);
        check("k1 neg", sx(avg_bus.avg_data), ROUND ? -1 : -2);
        send(131071); send(131071);
        check("k1 max", sx(avg_bus.avg_data), 131071);
        send(-131072); send(-131072);
        check("k1 min", sx(avg_bus.avg_data), -131072);

        // held valid is one sample only
        dec_log2 = 4'd0;
        adc_valid_in = 1'b0; tick();
        adc_data_in = 18'(77); adc_valid_in = 1'b1;
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (avg_bus.avg_valid) vcount++;
        end
        adc_valid_in = 1'b0;
        check("held valid results", vcount, 1);

        // dec_log2 changes mid-block are ignored until the next block
        dec_log2 = 4'd2;
        send(4); send(8);
        dec_log2 = 4'd3;
        send(12); send(16);
        check("mid-block k change busy", int'(busy), 0);
        check("mid-block k change valid", int'(avg_bus.avg_valid), 1);
        check("mid-block k change avg", sx(avg_bus.avg_data), 10);

        // back-pressure and overrun
        tick();
        dec_log2 = 4'd0;
        avg_bus.avg_ready = 1'b0;
        send(10); send(20); send(30);
        check("overrun held data", sx(avg_bus.avg_data), 10);
        check("overrun count", int'(overrun_cnt), 2);
        adc_valid_in = 1'b0; tick();
        adc_data_in = 18'(40); adc_valid_in = 1'b1; avg_bus.avg_ready = 1'b1;
        tick();
        adc_valid_in = 1'b0; avg_bus.avg_ready = 1'b0;
        check("ready+complete data", sx(avg_bus.avg_data), 40);
        check("ready+complete valid", int'(avg_bus.avg_valid), 1);
        check("ready+complete overrun", int'(overrun_cnt), 2);
        avg_bus.avg_ready = 1'b1;
        tick();
        check("drain valid", int'(avg_bus.avg_valid), 0);

        // enable=0 flushes a partial block
        dec_log2 = 4'd3;
        send(1); send(2); send(3); send(4); send(5);
        check("partial busy", int'(busy), 1);
        enable = 1'b0; tick(); enable = 1'b1;
        check("flush busy", int'(busy), 0);
        check("flush no output", int'(avg_bus.avg_valid), 0);
        send(100); send(-50); send(7); send(3); send(0); send(9); send(-20); send(35);
        check("post-flush avg", sx(avg_bus.avg_data), ROUND ? 11 : 10);

        // reset mid-block with a pending result
        tick();
        avg_bus.avg_ready = 1'b0;
        dec_log2 = 4'd0;
        send(7);
        dec_log2 = 4'd3;
        send(1); send(2);
        check("pre-reset pending", int'(avg_bus.avg_valid), 1);
        reset_int = 1'b1; tick(); reset_int = 1'b0;
        check("mid reset avg_data", sx(avg_bus.avg_data), 0);
        check("mid reset avg_valid", int'(avg_bus.avg_valid), 0);
        check("mid reset busy", int'(busy), 0);
        check("mid reset overrun", int'(overrun_cnt), 0);

        // random phase, checked by the model
        for (int i = 0; i < 6000; i++) begin
            adc_valid_in      = 1'($urandom_range(0, 1));
            adc_data_in       = 18'($urandom);
            avg_bus.avg_ready = ($urandom_range(0, 9) < 6);
            enable            = ($urandom_range(0, 49) != 0);
            dec_log2          = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15))
                                                             : 4'($urandom_range(0, 3));
            reset_int         = ($urandom_range(0, 799) == 0);
            tick();
        end
        reset_int = 1'b0;
        tick();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
